// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiply sequencer that borrows the shared ALU adder; yields low DATA_WIDTH bits of op1*op2.
// Optional MUL_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | cmdReady_out high, waiting for a command
// BUSY    | one multiplier bit per cycle, ALU claimed via aluBusy_out
// DONE    | product on result_out, resultValid_out held until accepted

module alu_mul_sequencer #(
  parameter int DATA_WIDTH_POW = 6,
  parameter int DATA_WIDTH     = 1 << DATA_WIDTH_POW,
  parameter int CNT_WIDTH      = DATA_WIDTH_POW + 1
) (
  input  logic                  clk_in,
  input  logic                  rstN_in,
  input  logic                  cmdValid_in,
  output logic                  cmdReady_out,
  input  logic [DATA_WIDTH-1:0] multiplicand_in,
  input  logic [DATA_WIDTH-1:0] multiplier_in,
  output logic [DATA_WIDTH-1:0] aluOperand1_out,
  output logic [DATA_WIDTH-1:0] aluOperand2_out,
  output logic [2:0]            aluOp_out,
  input  logic [DATA_WIDTH-1:0] aluResult_in,
  output logic                  aluBusy_out,
  output logic                  resultValid_out,
  input  logic                  resultReady_in,
  output logic [DATA_WIDTH-1:0] result_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0]           OP_ADD   = 3'b111;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] mcand;
  logic [DATA_WIDTH-1:0] mplier;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  earlyExit;

`ifdef MUL_EARLY_EXIT_EN
  // Once the multiplier is exhausted every remaining partial product is zero.
  assign earlyExit = (mplier == '0);
`else
  assign earlyExit = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (!rstN_in) begin
      state  <= ST_IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmdValid_in) begin
            acc    <= '0;
            mcand  <= multiplicand_in;
            mplier <= multiplier_in;
            cnt    <= '0;
            state  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (earlyExit) begin
            state <= ST_DONE;
          end else begin
            if (mplier[0]) acc <= aluResult_in;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_LAST) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (resultReady_in) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmdReady_out    = (state == ST_IDLE);
  assign aluBusy_out     = (state == ST_BUSY);
  assign resultValid_out = (state == ST_DONE);
  assign aluOperand1_out = acc;
  assign aluOperand2_out = mcand;
  assign aluOp_out       = OP_ADD;
  assign result_out      = acc;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer; the ALU adder is modelled inline.
// Build with +define+MUL_EARLY_EXIT_EN to exercise the early-exit latencies.

module tb_alu_mul_sequencer;

  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rstN;
  logic          cmdValid;
  logic          cmdReady;
  logic [DW-1:0] mcandIn;
  logic [DW-1:0] mplierIn;
  logic [DW-1:0] op1;
  logic [DW-1:0] op2;
  logic [2:0]    aluOp;
  logic [DW-1:0] aluResult;
  logic          aluBusy;
  logic          resultValid;
  logic          resultReady;
  logic [DW-1:0] result;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] sbQ[$];

  always #5 clk = ~clk;

  assign aluResult = op1 + op2;

  alu_mul_sequencer dut (
    .clk_in          (clk),
    .rstN_in         (rstN),
    .cmdValid_in     (cmdValid),
    .cmdReady_out    (cmdReady),
    .multiplicand_in (mcandIn),
    .multiplier_in   (mplierIn),
    .aluOperand1_out (op1),
    .aluOperand2_out (op2),
    .aluOp_out       (aluOp),
    .aluResult_in    (aluResult),
    .aluBusy_out     (aluBusy),
    .resultValid_out (resultValid),
    .resultReady_in  (resultReady),
    .result_out      (result)
  );

  function automatic int expLatency(input logic [DW-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int hi;
    hi = -1;
    for (int i = 0; i < DW; i++) if (b[i]) hi = i;
    if (hi < 0) return 1;
    return (hi + 2 > DW) ? DW : hi + 2;
`else
    return DW;
`endif
  endfunction

  // Present a command at a negedge; it is accepted on the following posedge.
  task automatic startCmd(input logic [DW-1:0] a, input logic [DW-1:0] b, input string name);
    checks++;
    if (cmdReady !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_before_cmd: got %b want 1", name, cmdReady);
    end
    mcandIn  = a;
    mplierIn = b;
    cmdValid = 1'b1;
    sbQ.push_back(a * b);
    @(negedge clk);
    cmdValid = 1'b0;
  endtask

  task automatic collect(input int expLat, input int holdCycles, input string name);
    int cyc;
    int busyCyc;
    logic [DW-1:0] exp;
    cyc = 0;
    busyCyc = 0;
    while (resultValid !== 1'b1 && cyc < 300) begin
      if (aluBusy === 1'b1) busyCyc++;
      checks++;
      if (aluOp !== 3'b111) begin
        failures++;
        $display("FAIL %s_aluop cyc %0d: got %b want 111", name, cyc, aluOp);
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (resultValid !== 1'b1) begin
      failures++;
      $display("FAIL %s_timeout: no resultValid after %0d cycles", name, cyc);
      if (sbQ.size() > 0) void'(sbQ.pop_front());
      return;
    end
    if (cyc != expLat) begin
      failures++;
      $display("FAIL %s_latency: got %0d want %0d", name, cyc, expLat);
    end
    checks++;
    if (busyCyc != expLat) begin
      failures++;
      $display("FAIL %s_busy_cycles: got %0d want %0d", name, busyCyc, expLat);
    end
    checks++;
    if (sbQ.size() == 0) begin
      failures++;
      $display("FAIL %s_scoreboard_empty: got result %h want none", name, result);
      return;
    end
    exp = sbQ.pop_front();
    if (result !== exp) begin
      failures++;
      $display("FAIL %s_result: got %h want %h", name, result, exp);
    end
    for (int i = 0; i < holdCycles; i++) begin
      cmdValid = i[0];
      mcandIn  = 64'hDEAD;
      mplierIn = 64'hBEEF;
      @(negedge clk);
      checks++;
      if (resultValid !== 1'b1 || result !== exp || cmdReady !== 1'b0) begin
        failures++;
        $display("FAIL %s_hold cyc %0d: got valid=%b result=%h ready=%b want valid=1 result=%h ready=0",
                 name, i, resultValid, result, cmdReady, exp);
      end
    end
    cmdValid    = 1'b0;
    resultReady = 1'b1;
    @(negedge clk);
    resultReady = 1'b0;
    checks++;
    if (cmdReady !== 1'b1 || resultValid !== 1'b0 || aluBusy !== 1'b0) begin
      failures++;
      $display("FAIL %s_return_idle: got ready=%b valid=%b busy=%b want 1 0 0",
               name, cmdReady, resultValid, aluBusy);
    end
  endtask

  task automatic runMul(input logic [DW-1:0] a, input logic [DW-1:0] b, input string name);
    startCmd(a, b, name);
    collect(expLatency(b), 0, name);
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    cmdValid = 1'b0;
    resultReady = 1'b0;
    mcandIn = '0;
    mplierIn = '0;
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checks++;
    if (cmdReady !== 1'b1 || resultValid !== 1'b0 || aluBusy !== 1'b0 || result !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got ready=%b valid=%b busy=%b result=%h want 1 0 0 0",
               cmdReady, resultValid, aluBusy, result);
    end
    checks++;
    if (op1 !== '0 || op2 !== '0 || aluOp !== 3'b111) begin
      failures++;
      $display("FAIL reset_alu_ports: got op1=%h op2=%h op=%b want 0 0 111", op1, op2, aluOp);
    end
  endtask

  task automatic test_basic();
    runMul(64'd3, 64'd5, "mul_3x5");
    runMul(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, "mul_wrap");
    runMul(64'hFFFF_FFFF_FFFF_FFFD, 64'd7, "mul_neg3x7");
    checks++;
    if ((64'hFFFF_FFFF_FFFF_FFFD * 64'd7) !== 64'hFFFF_FFFF_FFFF_FFEB || result !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      failures++;
      $display("FAIL mul_neg3x7_held: got %h want %h", result, 64'hFFFF_FFFF_FFFF_FFEB);
    end
    runMul(64'd0, 64'h1234_5678_9ABC_DEF0, "mul_zero_a");
  endtask

  task automatic test_backpressure();
    startCmd(64'd11, 64'd13, "backpressure");
    collect(expLatency(64'd13), 10, "backpressure");
  endtask

  task automatic test_reset_mid_busy();
    startCmd(64'h1111, 64'hFFFF_0000_FFFF_0001, "abort");
    repeat (20) @(negedge clk);
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    void'(sbQ.pop_back());
    checks++;
    if (cmdReady !== 1'b1 || resultValid !== 1'b0 || aluBusy !== 1'b0 ||
        result !== '0 || op1 !== '0 || op2 !== '0) begin
      failures++;
      $display("FAIL abort_reset_state: got ready=%b valid=%b busy=%b result=%h op1=%h op2=%h want 1 0 0 0 0 0",
               cmdReady, resultValid, aluBusy, result, op1, op2);
    end
    @(negedge clk);
    checks++;
    if (resultValid !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_valid: got %b want 0", resultValid);
    end
    runMul(64'd6, 64'd7, "after_abort_6x7");
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    for (int k = 0; k < 4; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (k == 3) b = b >> 40;
      runMul(a, b, "random");
    end
  endtask

`ifdef MUL_EARLY_EXIT_EN
  task automatic test_early_exit();
    runMul(64'd9, 64'd4, "early_9x4");
    runMul(64'd9, 64'd0, "early_9x0");
    runMul(64'd1, 64'h8000_0000_0000_0000, "early_1xmsb");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_reset_mid_busy();
    test_back_to_back();
`ifdef MUL_EARLY_EXIT_EN
    test_early_exit();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
